// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: a radix-2 shift-add multiplier and a restoring
// divider share one 2W-bit accumulator, followed by a sign fix-up step.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             cancel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_hi,
   output logic [WIDTH-1:0] out_lo,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]   ONES_W  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]      ONE_CW  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]      LOAD_CW = CW'(WIDTH);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIXUP = 2'd2, DONE = 2'd3} state_t;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + ONE_W;
   endfunction

   function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v, input logic is_signed);
      return (is_signed & v[WIDTH-1]) ? neg_w(v) : v;
   endfunction

   state_t             state_r, state_next_s;
   logic [2*WIDTH-1:0] acc_r;
   logic [WIDTH-1:0]   b_r;
   logic [CW-1:0]      cnt_r;
   logic               is_div_r, neg_q_r, neg_r_r, dbz_r;
   logic               accept_s, dbz_in_s;
   logic [WIDTH:0]     mul_sum_s, div_rem_s, div_diff_s;
   logic [2*WIDTH-1:0] mul_next_s, div_next_s, prod_neg_s;
   logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;

   assign in_ready = (state_r == IDLE);
   assign accept_s = in_valid & (state_r == IDLE) & ~cancel;
   assign dbz_in_s = op[1] & (src2 == ZERO_W);

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode; cancel overrides acceptance and completion
   always_comb begin
      state_next_s = state_r;
      if (cancel) begin
         state_next_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_next_s = dbz_in_s ? FIXUP : CALC;
               end else begin
                  state_next_s = IDLE;
               end
            end
            CALC: begin
               if (cnt_r == ONE_CW) begin
                  state_next_s = FIXUP;
               end else begin
                  state_next_s = CALC;
               end
            end
            FIXUP: state_next_s = DONE;
            DONE: begin
               if (out_ready) begin
                  state_next_s = IDLE;
               end else begin
                  state_next_s = DONE;
               end
            end
            default: state_next_s = IDLE;
         endcase
      end
   end

   // One iteration step: multiply adds into the upper half and shifts right,
   // divide shifts the partial remainder left and trial-subtracts the divisor
   always_comb begin
      mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
      mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      div_rem_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
      div_diff_s = div_rem_s - {1'b0, b_r};
      if (div_diff_s[WIDTH]) begin
         div_next_s = {div_rem_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end else begin
         div_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end
   end

   // Sign correction of the finished magnitude result
   always_comb begin
      prod_neg_s = ~acc_r + ONE_2W;
      fix_hi_s   = acc_r[2*WIDTH-1:WIDTH];
      fix_lo_s   = acc_r[WIDTH-1:0];
      if (is_div_r) begin
         fix_hi_s = neg_r_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
         fix_lo_s = neg_q_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
      end else if (neg_q_r) begin
         {fix_hi_s, fix_lo_s} = prod_neg_s;
      end else begin
         {fix_hi_s, fix_lo_s} = acc_r;
      end
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc_r       <= {(2*WIDTH){1'b0}};
         b_r         <= ZERO_W;
         cnt_r       <= {CW{1'b0}};
         is_div_r    <= 1'b0;
         neg_q_r     <= 1'b0;
         neg_r_r     <= 1'b0;
         dbz_r       <= 1'b0;
         out_valid   <= 1'b0;
         out_hi      <= ZERO_W;
         out_lo      <= ZERO_W;
         div_by_zero <= 1'b0;
      end else begin
         out_valid <= (state_next_s == DONE);
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  is_div_r <= op[1];
                  b_r      <= abs_w(src2, op[0]);
                  cnt_r    <= LOAD_CW;
                  dbz_r    <= dbz_in_s;
                  // divide by zero pre-loads the final result, no sign fix-up
                  if (dbz_in_s) begin
                     acc_r   <= {src1, ONES_W};
                     neg_q_r <= 1'b0;
                     neg_r_r <= 1'b0;
                  end else begin
                     acc_r   <= {ZERO_W, abs_w(src1, op[0])};
                     neg_q_r <= op[0] & (src1[WIDTH-1] ^ src2[WIDTH-1]);
                     neg_r_r <= (op == 2'b11) & src1[WIDTH-1];
                  end
               end
            end
            CALC: begin
               acc_r <= is_div_r ? div_next_s : mul_next_s;
               cnt_r <= cnt_r - ONE_CW;
            end
            FIXUP: begin
               if (!cancel) begin
                  out_hi      <= fix_hi_s;
                  out_lo      <= fix_lo_s;
                  div_by_zero <= dbz_r;
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter at WIDTH=32 (directed + random) and WIDTH=8 (random).
module tb_muldiv_iter;
   logic        clk, resetn;
   logic        d32_in_valid, d32_in_ready, d32_cancel, d32_out_valid, d32_out_ready, d32_dbz;
   logic [1:0]  d32_op;
   logic [31:0] d32_src1, d32_src2, d32_out_hi, d32_out_lo;
   logic        d8_in_valid, d8_in_ready, d8_cancel, d8_out_valid, d8_out_ready, d8_dbz;
   logic [1:0]  d8_op;
   logic [7:0]  d8_src1, d8_src2, d8_out_hi, d8_out_lo;

   int total = 0;
   int bad = 0;
   logic [64:0] exp32_q[$];
   logic [64:0] exp8_q[$];

   muldiv_iter #(.WIDTH(32)) u_d32 (
      .clk(clk), .resetn(resetn), .in_valid(d32_in_valid), .in_ready(d32_in_ready),
      .op(d32_op), .src1(d32_src1), .src2(d32_src2), .cancel(d32_cancel),
      .out_valid(d32_out_valid), .out_ready(d32_out_ready), .out_hi(d32_out_hi),
      .out_lo(d32_out_lo), .div_by_zero(d32_dbz));

   muldiv_iter #(.WIDTH(8)) u_d8 (
      .clk(clk), .resetn(resetn), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
      .op(d8_op), .src1(d8_src1), .src2(d8_src2), .cancel(d8_cancel),
      .out_valid(d8_out_valid), .out_ready(d8_out_ready), .out_hi(d8_out_hi),
      .out_lo(d8_out_lo), .div_by_zero(d8_dbz));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Independent reference: returns {dbz, hi[31:0], lo[31:0]} for a w-bit unit
   function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input int w);
      logic [63:0] mask, p, hi, lo;
      longint sa, sb, q, r;
      logic dz;
      mask = (64'd1 << w) - 64'd1;
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
      if (o[0] && a[w-1]) sa = sa - longint'(64'd1 << w);
      if (o[0] && b[w-1]) sb = sb - longint'(64'd1 << w);
      dz = 1'b0;
      if (!o[1]) begin
         p  = sa * sb;
         hi = (p >> w) & mask;
         lo = p & mask;
      end else if (b == 32'd0) begin
         dz = 1'b1;
         hi = {32'd0, a};
         lo = mask;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         hi = r;
         lo = q;
         hi = hi & mask;
         lo = lo & mask;
      end
      return {dz, hi[31:0], lo[31:0]};
   endfunction

   function automatic logic [31:0] pick(input int w);
      logic [31:0] mask, min_v;
      mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      min_v = 32'd1 << (w - 1);
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return mask;
         3: return min_v;
         4: return min_v - 32'd1;
         default: return $urandom & mask;
      endcase
   endfunction

   task automatic start32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [64:0] e);
      int n = 0;
      @(negedge clk);
      while (!d32_in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!d32_in_ready) check("d32_ready_timeout", 64'd0, 64'd1);
      d32_in_valid = 1'b1;
      d32_op = o;
      d32_src1 = a;
      d32_src2 = b;
      exp32_q.push_back(e);
      @(posedge clk);
      #1;
      d32_in_valid = 1'b0;
      d32_op = 2'($urandom);
      d32_src1 = $urandom;
      d32_src2 = $urandom;
   endtask

   task automatic finish32(input int exp_lat);
      int n = 0;
      logic [64:0] e;
      while (!d32_out_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("d32_latency", 64'(n), 64'(exp_lat));
      e = exp32_q.pop_front();
      if (d32_out_valid) begin
         check("d32_hi", {32'd0, d32_out_hi}, {32'd0, e[63:32]});
         check("d32_lo", {32'd0, d32_out_lo}, {32'd0, e[31:0]});
         check("d32_dbz", {63'd0, d32_dbz}, {63'd0, e[64]});
         if (d32_out_ready) begin
            @(posedge clk);
            #1;
            check("d32_valid_clear", {63'd0, d32_out_valid}, 64'd0);
         end
      end
   endtask

   task automatic op8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      logic [64:0] e;
      e = ref_model(o, {24'd0, a}, {24'd0, b}, 8);
      @(negedge clk);
      while (!d8_in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!d8_in_ready) check("d8_ready_timeout", 64'd0, 64'd1);
      d8_in_valid = 1'b1;
      d8_op = o;
      d8_src1 = a;
      d8_src2 = b;
      exp8_q.push_back(e);
      @(posedge clk);
      #1;
      d8_in_valid = 1'b0;
      d8_src1 = 8'($urandom);
      d8_src2 = 8'($urandom);
      n = 0;
      while (!d8_out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("d8_latency", 64'(n), (o[1] && b == 8'd0) ? 64'd1 : 64'd9);
      e = exp8_q.pop_front();
      check("d8_hi", {56'd0, d8_out_hi}, {56'd0, e[39:32]});
      check("d8_lo", {56'd0, d8_out_lo}, {56'd0, e[7:0]});
      check("d8_dbz", {63'd0, d8_dbz}, {63'd0, e[64]});
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      logic [64:0] e;
      int          lat;
   } vec_t;

   vec_t dir_v[8];
   logic [1:0]  ro;
   logic [31:0] ra, rb;
   int seen;

   initial begin
      dir_v[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001}, 33};
      dir_v[1] = '{2'b01, 32'hFFFF_FFFD, 32'd7, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB}, 33};
      dir_v[2] = '{2'b10, 32'd7, 32'd2, {1'b0, 32'd1, 32'd3}, 33};
      dir_v[3] = '{2'b11, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33};
      dir_v[4] = '{2'b11, 32'd7, 32'hFFFF_FFFE, {1'b0, 32'd1, 32'hFFFF_FFFD}, 33};
      dir_v[5] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'd0, 32'h8000_0000}, 33};
      dir_v[6] = '{2'b10, 32'd5, 32'd0, {1'b1, 32'd5, 32'hFFFF_FFFF}, 1};
      dir_v[7] = '{2'b11, 32'hFFFF_FFFB, 32'd0, {1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1};

      resetn = 1'b0;
      d32_in_valid = 1'b0; d32_op = 2'b00; d32_src1 = 32'd0; d32_src2 = 32'd0;
      d32_cancel = 1'b0; d32_out_ready = 1'b1;
      d8_in_valid = 1'b0; d8_op = 2'b00; d8_src1 = 8'd0; d8_src2 = 8'd0;
      d8_cancel = 1'b0; d8_out_ready = 1'b1;
      #1;
      check("rst_in_ready", {63'd0, d32_in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, d32_out_valid}, 64'd0);
      check("rst_hi_lo", {d32_out_hi, d32_out_lo}, 64'd0);
      check("rst_dbz", {63'd0, d32_dbz}, 64'd0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      foreach (dir_v[i]) begin
         start32(dir_v[i].o, dir_v[i].a, dir_v[i].b, dir_v[i].e);
         finish32(dir_v[i].lat);
      end

      // Backpressure: result held, busy, inputs ignored
      d32_out_ready = 1'b0;
      start32(2'b00, 32'd3, 32'd5, {1'b0, 32'd0, 32'd15});
      finish32(33);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         d32_src1 = $urandom;
         d32_src2 = $urandom;
         check("bp_hold", {d32_out_hi, d32_out_lo}, {32'd0, 32'd15});
         check("bp_busy", {62'd0, d32_in_ready, d32_out_valid}, 64'd1);
      end
      @(negedge clk);
      d32_out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release", {62'd0, d32_in_ready, d32_out_valid}, 64'd2);
      check("bp_keep", {d32_out_hi, d32_out_lo}, {32'd0, 32'd15});
      start32(2'b01, 32'hFFFF_FFFD, 32'd7, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
      check("bp_next_accept", {63'd0, d32_in_ready}, 64'd0);
      finish32(33);

      // Cancel at CALC cycle 10
      start32(2'b11, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14});
      repeat (9) @(posedge clk);
      @(negedge clk);
      d32_cancel = 1'b1;
      @(posedge clk);
      #1;
      d32_cancel = 1'b0;
      void'(exp32_q.pop_back());
      check("cancel_idle", {62'd0, d32_in_ready, d32_out_valid}, 64'd2);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (d32_out_valid) seen++;
      end
      check("cancel_no_valid", 64'(seen), 64'd0);
      start32(2'b01, 32'd6, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
      finish32(33);

      // Cancel in IDLE blocks acceptance
      @(negedge clk);
      d32_in_valid = 1'b1;
      d32_cancel = 1'b1;
      @(posedge clk);
      #1;
      d32_in_valid = 1'b0;
      d32_cancel = 1'b0;
      check("cancel_blocks", {63'd0, d32_in_ready}, 64'd1);

      // Asynchronous reset mid-CALC
      start32(2'b00, 32'd1234, 32'd5678, {1'b0, 32'd0, 32'd7006652});
      repeat (5) @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check("arst_hi_lo", {d32_out_hi, d32_out_lo}, 64'd0);
      check("arst_idle", {62'd0, d32_in_ready, d32_out_valid}, 64'd2);
      void'(exp32_q.pop_back());
      @(negedge clk);
      resetn = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (d32_out_valid) seen++;
      end
      check("arst_no_valid", 64'(seen), 64'd0);

      // Random against the reference model
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom);
         ra = pick(32);
         rb = pick(32);
         start32(ro, ra, rb, ref_model(ro, ra, rb, 32));
         finish32((ro[1] && rb == 32'd0) ? 1 : 33);
      end
      for (int i = 0; i < 200; i++) begin
         ro = 2'($urandom);
         ra = pick(8);
         rb = pick(8);
         op8(ro, ra[7:0], rb[7:0]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
